adc_frame_seq: RTL and testbench
================================

# adc_frame_seq

Frame sequencer that generates the serial ADC link consumed by the 4-channel deserializer: one frame is a 14-bit header word 14'h0FFF followed by four 14-bit channel words, each framed by cs and shifted MSB-first on sck. It sits between the sample source (four parallel 14-bit channel words) and the serial link. It owns frame timing, word ordering, single-shot and continuous operation, and abort.

## Interface
- DIV, 2: sck half-period in clk cycles (>=1).
- GAP, 4: cs-high cycles between words (>=1).
- HEAD, 14'h0FFF: header word sent first in every frame.
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle frame request; ignored while busy.
- cont  input  1  continuous mode; sampled in the done cycle.
- abort  input  1  synchronous abort of the frame in progress.
- ch1, ch2, ch3, ch4  input  14 each  channel samples; latched at frame start.
- sck  output  1  serial clock, idle low.
- cs  output  1  word frame, idle high, low while a word shifts.
- mosi  output  1  serial data, MSB first.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame completion.
- frame_cnt  output  8  count of completed frames, wraps 255->0.

## Operation
- States:
  - IDLE: cs=1, sck=0, mosi=0.
  - SHIFT: cs=0, 14 bits.
  - GAP: cs=1, sck=0.
- Frame launch:
  - IDLE & start: latch ch1..ch4 into shadow registers and set word_idx=0.
  - Go to SHIFT with cs=0, sck=0, mosi=HEAD[13], busy=1.
- SHIFT, per bit:
  - sck low for DIV cycles, then high for DIV cycles.
  - mosi changes only at the start of the low phase and is stable across the sck rising edge.
- End of word: at the end of the 14th high phase, sck=0 and cs=1 on the same edge, mosi held. Go to GAP.
- GAP:
  - Count GAP cycles.
  - If word_idx<4: increment word_idx, return to SHIFT with cs=0 and mosi=next word[13].
- Word order: word_idx 0=HEAD, 1=ch1, 2=ch2, 3=ch3, 4=ch4, all taken from the shadow registers. Input changes mid-frame have no effect.
- Completion: in the last GAP cycle of word 4, done=1 and frame_cnt increments on the next edge. Then:
  - If cont=1 or start=1 in that cycle: re-latch channels and enter SHIFT directly. busy stays 1 and there are no idle cycles.
  - Otherwise: go to IDLE with busy=0 and mosi=0.
- abort (any non-IDLE state):
  - Next edge forces IDLE, cs=1, sck=0, mosi=0, busy=0.
  - No done pulse, frame_cnt unchanged.
  - abort has priority over start in the same cycle.
- start while busy: ignored (no queuing).

## Timing
- Reset values: sck=0, cs=1, mosi=0, busy=0, done=0, frame_cnt=0, shadow registers=0, state IDLE.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous). No partial word is resumed.
- Launch latency: the edge that samples start drives cs=0 and busy=1.
- Lengths:
  - Word: 28*DIV cycles with cs low, then GAP cycles with cs high.
  - Frame: 5*(28*DIV+GAP) cycles. Cycle 0 is the first cycle after the start edge.
- done is high in cycle 5*(28*DIV+GAP)-1, the last GAP cycle. With DIV=2, GAP=4 that is cycle 299, and busy falls after it.
- Per frame: exactly 70 sck rising edges and 5 cs rising edges.
- Back-to-back frames in cont mode: period exactly 5*(28*DIV+GAP) cycles.

## Test plan
- Single frame:
  - Stimulus: DIV=2, GAP=4, ch1=14'h0123, ch2=14'h1ABC, ch3=14'h0000, ch4=14'h3FFF, one start pulse.
  - Required: bits sampled on sck rising edges give 0FFF, 0123, 1ABC, 0000, 3FFF; done in cycle 299; frame_cnt=1; busy low from cycle 300.
- Shadow latch:
  - Stimulus: change ch1..ch4 to 14'h2AAA at cycle 10 of the frame.
  - Required: transmitted words still match the values at start; the next frame sends 2AAA.
- Continuous mode:
  - Stimulus: cont=1 for 3 frames.
  - Required: cs falls in cycle 300 and 600, no idle gap between frames, frame_cnt=3, busy continuously high.
- Abort and ignored start:
  - Stimulus: abort in cycle 150 (mid word 2); separately, start repeated during busy.
  - Required for abort: next cycle cs=1, sck=0, busy=0, no done, frame_cnt unchanged; a new start gives a clean full frame.
  - Required for repeated start: no effect.
- Reset mid-frame:
  - Stimulus: rstn low in cycle 77.
  - Required: outputs at reset values immediately; after release, a start gives a correct frame.
- Counter wrap and minimum timing:
  - Stimulus: DIV=1, GAP=1, 256 frames.
  - Required: frame period 145 cycles; frame_cnt wraps 255->0.
  - Required: loopback into the deserializer model recovers ch1..ch4 exactly every frame.

Source files
------------

// File: rtl/adc_frame_seq.sv
// Serial ADC frame sequencer: emits HEAD then ch1..ch4 as 14-bit MSB-first words,
// each framed by cs, with single-shot, continuous and abort control.
module adc_frame_seq #(
  parameter int          DIV  = 2,
  parameter int          GAP  = 4,
  parameter logic [13:0] HEAD = 14'h0FFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  input  logic [13:0] ch1,
  input  logic [13:0] ch2,
  input  logic [13:0] ch3,
  input  logic [13:0] ch4,
  output logic        sck,
  output logic        cs,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [3:0]        bit_q, bit_d;
  logic [2:0]        word_q, word_d;
  logic [13:0]       sr_q, sr_d;
  logic [3:0][13:0]  sh_q, sh_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic [7:0]        fc_q, fc_d;
  logic              done_c;
  logic              launch;
  logic [13:0]       nxt_word;

  function automatic logic [13:0] word_sel(input logic [2:0] idx,
                                           input logic [3:0][13:0] sh);
    case (idx)
      3'd1:    word_sel = sh[0];
      3'd2:    word_sel = sh[1];
      3'd3:    word_sel = sh[2];
      3'd4:    word_sel = sh[3];
      default: word_sel = HEAD;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    gap_d    = gap_q;
    bit_d    = bit_q;
    word_d   = word_q;
    sr_d     = sr_q;
    sh_d     = sh_q;
    sck_d    = sck_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    fc_d     = fc_q;
    done_c   = 1'b0;
    launch   = 1'b0;
    nxt_word = word_sel(word_q + 3'd1, sh_q);

    case (state_q)
      S_IDLE: begin
        if (start) launch = 1'b1;
      end
      S_SHIFT: begin
        if (div_q == DW'(DIV - 1)) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q == 4'd13) begin
            sck_d   = 1'b0;
            cs_d    = 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            // Next bit presented at the start of the low phase.
            sck_d  = 1'b0;
            bit_d  = bit_q + 4'd1;
            sr_d   = {sr_q[12:0], 1'b0};
            mosi_d = sr_q[12];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          if (word_q != 3'd4) begin
            word_d  = word_q + 3'd1;
            sr_d    = nxt_word;
            mosi_d  = nxt_word[13];
            cs_d    = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            state_d = S_SHIFT;
          end else begin
            done_c = 1'b1;
            fc_d   = fc_q + 8'd1;
            if (cont || start) begin
              launch = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              mosi_d  = 1'b0;
            end
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      sh_d    = {ch4, ch3, ch2, ch1};
      word_d  = '0;
      sr_d    = HEAD;
      mosi_d  = HEAD[13];
      cs_d    = 1'b0;
      sck_d   = 1'b0;
      busy_d  = 1'b1;
      div_d   = '0;
      bit_d   = '0;
      state_d = S_SHIFT;
    end

    // Abort wins over any launch or completion decided above.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sh_d    = sh_q;
      cs_d    = 1'b1;
      sck_d   = 1'b0;
      mosi_d  = 1'b0;
      busy_d  = 1'b0;
      done_c  = 1'b0;
      fc_d    = fc_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      sr_q    <= '0;
      sh_q    <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      sr_q    <= sr_d;
      sh_q    <= sh_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      fc_q    <= fc_d;
    end
  end

  assign sck       = sck_q;
  assign cs        = cs_q;
  assign mosi      = mosi_q;
  assign busy      = busy_q;
  assign done      = done_c;
  assign frame_cnt = fc_q;

endmodule

// File: tb/tb_adc_frame_seq.sv
// Bench for adc_frame_seq: expected words queued at frame launch, compared
// against words recovered from the serial link by a deserializer model.
module tb_adc_frame_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, cont, abort;
  logic [13:0] c1, c2, c3, c4;
  logic        sck, cs, mosi, busy, done;
  logic [7:0]  fc;

  logic        start2, cont2, abort2;
  logic [13:0] d1, d2, d3, d4;
  logic        sck2, cs2, mosi2, busy2, done2;
  logic [7:0]  fc2;

  int          checks = 0;
  int          failures = 0;
  int          busy_low = 0;
  logic [7:0]  exp_fc = '0;
  logic [7:0]  exp_fc2 = '0;
  logic [13:0] q1[$];
  logic [13:0] q2[$];

  always #5 clk = ~clk;

  adc_frame_seq #(.DIV(2), .GAP(4), .HEAD(14'h0FFF)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort),
    .ch1(c1), .ch2(c2), .ch3(c3), .ch4(c4),
    .sck(sck), .cs(cs), .mosi(mosi), .busy(busy), .done(done), .frame_cnt(fc)
  );

  adc_frame_seq #(.DIV(1), .GAP(1), .HEAD(14'h0FFF)) dut_min (
    .clk(clk), .rstn(rstn), .start(start2), .cont(cont2), .abort(abort2),
    .ch1(d1), .ch2(d2), .ch3(d3), .ch4(d4),
    .sck(sck2), .cs(cs2), .mosi(mosi2), .busy(busy2), .done(done2), .frame_cnt(fc2)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Deserializer models: shift mosi on each sck rise while cs is low.
  logic [13:0] sh1, sh2;
  int          nb1, nb2;
  logic        sckp1 = 1'b0, csp1 = 1'b1, sckp2 = 1'b0, csp2 = 1'b1;

  always @(negedge clk) begin
    if (!rstn) begin
      nb1 = 0;
    end else begin
      if (sck && !sckp1 && !cs) begin sh1 = {sh1[12:0], mosi}; nb1++; end
      if (cs && !csp1) begin
        if (nb1 == 14) begin
          chk("word1_avail", int'(q1.size() > 0), 1);
          if (q1.size() > 0) chk("word1", sh1, q1.pop_front());
        end
        nb1 = 0;
      end
    end
    sckp1 = sck;
    csp1  = cs;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      nb2 = 0;
    end else begin
      if (sck2 && !sckp2 && !cs2) begin sh2 = {sh2[12:0], mosi2}; nb2++; end
      if (cs2 && !csp2) begin
        if (nb2 == 14) begin
          chk("word2_avail", int'(q2.size() > 0), 1);
          if (q2.size() > 0) chk("word2", sh2, q2.pop_front());
        end
        nb2 = 0;
      end
    end
    sckp2 = sck2;
    csp2  = cs2;
  end

  task automatic push1();
    q1.push_back(14'h0FFF); q1.push_back(c1); q1.push_back(c2);
    q1.push_back(c3); q1.push_back(c4);
  endtask

  task automatic launch1();
    @(negedge clk);
    start = 1'b1;
    push1();
    @(posedge clk); #1;
    start = 1'b0;
    chk("launch_cs", cs, 0);
    chk("launch_busy", busy, 1);
  endtask

  // Runs DUT1 from cycle 0 until done; optional mid-frame events by cycle number.
  task automatic run1(input int chg_at, input int abort_at, input int dup_at,
                      input int rst_at, output int dcyc);
    dcyc = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (c == chg_at) begin c1 = 14'h2AAA; c2 = 14'h2AAA; c3 = 14'h2AAA; c4 = 14'h2AAA; end
      if (c == dup_at) start = 1'b1;
      else if (c == dup_at + 1) start = 1'b0;
      if (c == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_cs", cs, 1);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_fc", fc, exp_fc);
        q1.delete();
        return;
      end
      if (c == rst_at) begin
        rstn = 1'b0;
        #1;
        chk("rst_sck", sck, 0);
        chk("rst_cs", cs, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fc", fc, 0);
        exp_fc = '0;
        q1.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (done) begin
        dcyc = c;
        return;
      end
    end
    chk("run1_timeout", 1, 0);
  endtask

  task automatic single1(input int chg_at, input int dup_at);
    int d;
    launch1();
    run1(chg_at, -1, dup_at, -1, d);
    chk("done_cycle", d, 299);
    exp_fc++;
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("fc", fc, exp_fc);
  endtask

  initial begin
    int d;
    rstn = 1'b0; start = 0; cont = 0; abort = 0;
    start2 = 0; cont2 = 0; abort2 = 0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    repeat (3) @(negedge clk);
    chk("reset_sck", sck, 0);
    chk("reset_cs", cs, 1);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fc", fc, 0);
    rstn = 1'b1;
    @(negedge clk);

    c1 = 14'h0123; c2 = 14'h1ABC; c3 = 14'h0000; c4 = 14'h3FFF;
    single1(-1, -1);

    single1(10, -1);
    single1(-1, -1);

    c1 = 14'h0555; c2 = 14'h3001; c3 = 14'h1234; c4 = 14'h0F0F;
    single1(-1, 50);

    busy_low = 0;
    cont = 1'b1;
    launch1();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) cont = 1'b0;
      run1(-1, -1, -1, -1, d);
      chk("cont_done_cycle", d, 299);
      exp_fc++;
      if (f < 2) begin
        push1();
        @(posedge clk); #1;
        chk("cont_cs_fall", cs, 0);
        chk("cont_busy", busy, 1);
      end else begin
        @(posedge clk); #1;
        chk("cont_busy_end", busy, 0);
      end
      chk("cont_fc", fc, exp_fc);
    end
    chk("cont_busy_gaps", busy_low, 0);

    c1 = 14'h1111; c2 = 14'h2222; c3 = 14'h3333; c4 = 14'h0444;
    launch1();
    run1(-1, 150, -1, -1, d);
    single1(-1, -1);

    launch1();
    run1(-1, -1, -1, 77, d);
    @(negedge clk);
    single1(-1, -1);

    d1 = 14'($urandom); d2 = 14'($urandom); d3 = 14'($urandom); d4 = 14'($urandom);
    cont2 = 1'b1;
    @(negedge clk);
    start2 = 1'b1;
    q2.push_back(14'h0FFF); q2.push_back(d1); q2.push_back(d2);
    q2.push_back(d3); q2.push_back(d4);
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int f = 0; f < 256; f++) begin
      int dc;
      dc = -1;
      if (f == 255) cont2 = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (c == 3 && f < 255) begin
          d1 = 14'($urandom); d2 = 14'($urandom); d3 = 14'($urandom); d4 = 14'($urandom);
          q2.push_back(14'h0FFF); q2.push_back(d1); q2.push_back(d2);
          q2.push_back(d3); q2.push_back(d4);
        end
        if (done2) begin dc = c; break; end
      end
      chk("min_period", dc, 144);
      @(posedge clk); #1;
      exp_fc2 = exp_fc2 + 8'd1;
      chk("min_fc", fc2, exp_fc2);
    end
    chk("min_wrap_fc", fc2, 0);
    chk("min_busy_end", busy2, 0);

    repeat (4) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
